// File: rtl/spi_rx_sync.sv
// rtl/spi_rx_sync.sv - SPI slave receiver with clk-domain synchronisers and a receive buffer
// SPI_RX_FIFO_EN selects a DEPTH-entry FIFO; undefined gives a single holding register.
module spi_rx_sync #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_active,
  output logic             overrun,
  output logic             short_frame,
  input  logic             overrun_clr
);

  localparam int              CW          = $clog2(WIDTH);
  localparam logic            IDLE_SCLK   = (CPOL != 0);
  localparam logic            SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));
  localparam logic [CW-1:0]   LAST_BIT    = CW'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s, sclk_q, cs_q;
  logic                   sample_edge, cs_rise, cs_fall, shift_en, push;
  logic                   full, pop, do_push;
  logic [CW-1:0]          bit_cnt, base_cnt;
  logic [WIDTH-1:0]       shreg, base_sr, next_sr;

  // Idle-level reset values keep the edge detectors quiet after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{IDLE_SCLK}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= IDLE_SCLK;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s       = sclk_sync[SYNC_STAGES-1];
  assign cs_s         = cs_sync[SYNC_STAGES-1];
  assign mosi_s       = mosi_sync[SYNC_STAGES-1];
  assign frame_active = ~cs_s;

  assign sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_q) : (~sclk_s & sclk_q);
  assign cs_rise     = cs_s & ~cs_q;
  assign cs_fall     = ~cs_s & cs_q;
  assign shift_en    = sample_edge & ~cs_s;

  // A sample coinciding with the cs_n falling edge starts a fresh word.
  assign base_cnt = cs_fall ? '0 : bit_cnt;
  assign base_sr  = cs_fall ? '0 : shreg;
  assign next_sr  = (MSB_FIRST != 0) ? {base_sr[WIDTH-2:0], mosi_s}
                                     : {mosi_s, base_sr[WIDTH-1:1]};
  assign push     = shift_en & (base_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      short_frame <= 1'b0;
    end else begin
      short_frame <= cs_rise & (bit_cnt != '0);
      if (shift_en) begin
        shreg   <= push ? '0 : next_sr;
        bit_cnt <= push ? '0 : base_cnt + CW'(1);
      end else if (cs_rise || cs_fall) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end
    end
  end

  assign pop     = rx_valid & rx_ready;
  assign do_push = push & (~full | pop);

`ifdef SPI_RX_FIFO_EN
  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= next_sr;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full     = (count == DEPTH_C);
  assign rx_valid = (count != '0);
  assign rx_data  = mem[rd_ptr];
`else
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (do_push) begin
      hold_data  <= next_sr;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign full     = hold_valid;
  assign rx_valid = hold_valid;
  assign rx_data  = hold_data;
`endif

  // A set event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      overrun <= 1'b0;
    else if (push & full & ~pop)     overrun <= 1'b1;
    else if (overrun_clr)            overrun <= 1'b0;
  end

endmodule

// File: tb/tb_spi_rx_sync.sv
// tb/tb_spi_rx_sync.sv - randomized self-checking bench for spi_rx_sync
// Instances 0..3 cover modes 0..3 MSB-first, instance 4 is mode 0 LSB-first.
module tb_spi_rx_sync;
  localparam int W = 8, DEPTH = 4, SS = 2, HALF = 8;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] sclk, cs_n, mosi, rx_ready, overrun_clr;
  logic [4:0] rx_valid, frame_active, overrun, short_frame;
  logic [4:0][7:0] rx_data;

  int errors = 0, checks = 0;
  logic [7:0] got [5][32];
  int got_n [5] = '{default: 0};
  int sf_n  [5] = '{default: 0};
  logic [7:0] exp_q [$];
  logic exp_ovr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    spi_rx_sync #(
      .WIDTH(W), .DEPTH(DEPTH),
      .CPOL((g == 2 || g == 3) ? 1 : 0), .CPHA((g == 1 || g == 3) ? 1 : 0),
      .MSB_FIRST((g == 4) ? 0 : 1), .SYNC_STAGES(SS)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk[g]), .cs_n(cs_n[g]), .mosi(mosi[g]),
      .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
      .frame_active(frame_active[g]), .overrun(overrun[g]),
      .short_frame(short_frame[g]), .overrun_clr(overrun_clr[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < 5; g++) begin
      if (rx_valid[g] && rx_ready[g]) begin
        got[g][got_n[g] % 32] <= rx_data[g];
        got_n[g] <= got_n[g] + 1;
      end
      if (short_frame[g]) sf_n[g] <= sf_n[g] + 1;
    end
  end

  function automatic logic [7:0] expect_word(input int idx, input logic [7:0] w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = w[7-k];
    return (idx == 4) ? r : w;
  endfunction

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_bit(input int idx, input logic b);
    logic cpol, cpha;
    cpol = (idx == 2 || idx == 3);
    cpha = (idx == 1 || idx == 3);
    if (!cpha) begin
      mosi[idx] = b; half_wait(); sclk[idx] = ~cpol; half_wait(); sclk[idx] = cpol;
    end else begin
      sclk[idx] = ~cpol; mosi[idx] = b; half_wait(); sclk[idx] = cpol; half_wait();
    end
  endtask

  task automatic send_word(input int idx, input logic [7:0] w);
    for (int k = 7; k >= 0; k--) spi_bit(idx, w[k]);
  endtask

  task automatic cs_high(input int idx);
    half_wait(); cs_n[idx] = 1'b1; half_wait();
  endtask

  task automatic check_pops(input int idx, input int base, input string name);
    int t = 0;
    while (got_n[idx] < base + exp_q.size() && t < 400) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    checks++;
    if (got_n[idx] != base + exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d words, expected %0d", name, got_n[idx] - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got[idx][(base + i) % 32] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s word %0d: got %h expected %h", name, i, got[idx][(base + i) % 32], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 5; g++) begin
      checks++;
      if ({rx_data[g], rx_valid[g], overrun[g], short_frame[g], frame_active[g]} !== 12'h0) begin
        errors++;
        $display("FAIL reset inst%0d: outputs %h expected 0", g,
                 {rx_data[g], rx_valid[g], overrun[g], short_frame[g], frame_active[g]});
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] w = 8'hA5;
    int n = 0, sf0 = sf_n[0], base = got_n[0];
    rx_ready[0] = 1'b0;
    cs_n[0] = 1'b0;
    for (int k = 7; k >= 1; k--) spi_bit(0, w[k]);
    checks++;
    if (frame_active[0] !== 1'b1) begin errors++; $display("FAIL frame_active: got %b expected 1", frame_active[0]); end
    mosi[0] = w[0]; half_wait(); sclk[0] = 1'b1;
    while (n < 10) begin
      @(posedge clk); #1; n++;
      if (rx_valid[0]) break;
    end
    checks++;
    if (n != SS + 1) begin errors++; $display("FAIL valid_latency: got %0d cycles expected %0d", n, SS + 1); end
    half_wait(); sclk[0] = 1'b0;
    cs_high(0);
    checks++;
    if (rx_data[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", rx_data[0]); end
    checks++;
    if (sf_n[0] != sf0) begin errors++; $display("FAIL single_short: got %0d pulses expected 0", sf_n[0] - sf0); end
    exp_q = {8'hA5};
    rx_ready[0] = 1'b1;
    check_pops(0, base, "single_pop");
    checks++;
    if (rx_valid[0] !== 1'b0) begin errors++; $display("FAIL single_empty: rx_valid %b expected 0", rx_valid[0]); end
  endtask

  task automatic test_modes();
    for (int m = 0; m < 5; m++) begin
      for (int f = 0; f < 3; f++) begin
        int base = got_n[m], sf0 = sf_n[m], nw;
        logic [7:0] w;
        rx_ready[m] = 1'b1;
        exp_q = {};
        cs_n[m] = 1'b0;
        if (f == 0) begin
          if (m == 4) begin send_word(m, 8'h80); exp_q.push_back(8'h01); end
          else begin
            send_word(m, 8'h3C); exp_q.push_back(8'h3C);
            send_word(m, 8'hC3); exp_q.push_back(8'hC3);
          end
        end else begin
          nw = $urandom_range(1, 3);
          for (int i = 0; i < nw; i++) begin
            w = 8'($urandom);
            send_word(m, w);
            exp_q.push_back(expect_word(m, w));
          end
        end
        cs_high(m);
        check_pops(m, base, $sformatf("mode%0d_frame%0d", m, f));
        checks++;
        if (overrun[m] !== 1'b0 || sf_n[m] != sf0) begin
          errors++;
          $display("FAIL mode%0d_flags: overrun %b short %0d expected 0 0", m, overrun[m], sf_n[m] - sf0);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int base;
    rx_ready[0] = 1'b0;
    exp_q = {};
    exp_ovr = 1'b0;
    cs_n[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_word(0, 8'(i));
      if (exp_q.size() < CAP) exp_q.push_back(8'(i)); else exp_ovr = 1'b1;
      checks++;
      if (overrun[0] !== exp_ovr) begin
        errors++; $display("FAIL overrun_after_%0d: got %b expected %b", i, overrun[0], exp_ovr);
      end
    end
    cs_high(0);
    base = got_n[0];
    rx_ready[0] = 1'b1;
    check_pops(0, base, "overrun_drain");
    rx_ready[0] = 1'b0;
    checks++;
    if (overrun[0] !== 1'b1 || rx_valid[0] !== 1'b0) begin
      errors++; $display("FAIL overrun_sticky: overrun %b valid %b expected 1 0", overrun[0], rx_valid[0]);
    end
    overrun_clr[0] = 1'b1; @(negedge clk); overrun_clr[0] = 1'b0; @(negedge clk);
    checks++;
    if (overrun[0] !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %b expected 0", overrun[0]); end
  endtask

  task automatic test_short();
    int sf0 = sf_n[0], base = got_n[0];
    rx_ready[0] = 1'b1;
    cs_n[0] = 1'b0;
    for (int k = 0; k < 5; k++) spi_bit(0, 1'($urandom));
    cs_high(0);
    checks++;
    if (sf_n[0] != sf0 + 1 || got_n[0] != base) begin
      errors++; $display("FAIL short_frame: pulses %0d pops %0d expected 1 0", sf_n[0] - sf0, got_n[0] - base);
    end
    exp_q = {8'h7E};
    cs_n[0] = 1'b0; send_word(0, 8'h7E); cs_high(0);
    check_pops(0, base, "after_short");
  endtask

  task automatic test_reset_mid();
    int base;
    rx_ready[0] = 1'b0;
    cs_n[0] = 1'b0; send_word(0, 8'h5A); cs_high(0);
    cs_n[0] = 1'b0;
    for (int k = 0; k < 4; k++) spi_bit(0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_data[0], rx_valid[0], overrun[0], short_frame[0], frame_active[0]} !== 12'h0) begin
      errors++; $display("FAIL reset_mid: outputs %h expected 0",
                         {rx_data[0], rx_valid[0], overrun[0], short_frame[0], frame_active[0]});
    end
    cs_n[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    base = got_n[0];
    rx_ready[0] = 1'b1;
    exp_q = {8'h99};
    cs_n[0] = 1'b0; send_word(0, 8'h99); cs_high(0);
    check_pops(0, base, "after_reset");
  endtask

  initial begin
    sclk = 5'b01100; cs_n = '1; mosi = '0; rx_ready = '0; overrun_clr = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    test_single();
    test_modes();
    test_overrun();
    test_short();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
